// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
//   Shared types and constants for the memory port arbiter.
//   - STAT_W     : width of every statistics counter
//   - IDX_MAX_W  : storage width of a requester index in an in-flight entry
//                  (supports up to 256 requesters)
//   - idx_w()    : index width needed to encode a requester number
//   - inflight_t : one stage of the response routing pipeline
//   Optional statistics are enabled with the macro MEM_ARB_STATS_EN
//   (consumed by mem_port_arbiter).
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int STAT_W    = 32;
  localparam int IDX_MAX_W = 8;

  // Width of an encoded requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // A response slot: valid marks a granted access, idx names its requester.
  typedef struct packed {
    logic                 valid;
    logic [IDX_MAX_W-1:0] idx;
  } inflight_t;

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin selector. Scans requesters starting at ptr_i
//   and wrapping modulo NUM_REQ; the first one with its request bit set wins.
//   Ports:
//     req_i   in  NUM_REQ  eligible requests
//     ptr_i   in  IDX_W    highest-priority requester this cycle
//     gnt_o   out NUM_REQ  one-hot winner (all zero if no request)
//     idx_o   out IDX_W    encoded winner
//     valid_o out 1        a winner exists
// ---------------------------------------------------------------------------
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk offsets from farthest to nearest so the requester closest to the
  // pointer overwrites any later candidate and ends up as the winner.
  always_comb begin
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand     = (int'(ptr_i) + off) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (req_i[cand_idx]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
    gnt_o = valid_o ? (NUM_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Round-robin arbiter sharing one single-port RAM between NUM_REQ
//   requesters. At most one access is issued per cycle; read data (and write
//   acknowledges) are routed back to the issuing requester exactly
//   RAM_LATENCY cycles after the grant through an in-flight index pipeline.
//   Ports:
//     clk_i, rst_ni        clock, asynchronous active-low reset
//     req_i/we_i           per-requester request and write enable
//     addr_i/wdata_i/be_i  packed per-requester payload (slice i = requester i)
//     gnt_o                one-hot grant (combinational, same cycle)
//     rvalid_o             one-hot response valid
//     rdata_o              response data, broadcast; 0 when no response
//     mem_ready_i          RAM accepts an access this cycle
//     mem_req_o/we/addr/wdata/be  RAM access of the winner (0 when idle)
//     mem_rdata_i          RAM read data
//   Optional (macro MEM_ARB_STATS_EN):
//     stat_gnt_cnt_o       per-requester saturating grant counters
//     stat_conflict_cnt_o  saturating count of cycles with >=2 requests
//                          while the RAM was ready
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int RAM_LATENCY = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ-1:0]             we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  wdata_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] be_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic [NUM_REQ-1:0]             rvalid_o,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  input  logic                           mem_ready_i,
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [ADDR_WIDTH-1:0]          mem_addr_o,
  output logic [DATA_WIDTH-1:0]          mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]        mem_be_o,
  input  logic [DATA_WIDTH-1:0]          mem_rdata_i
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]      stat_gnt_cnt_o,
  output logic [STAT_W-1:0]              stat_conflict_cnt_o
`endif
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int BE_W  = DATA_WIDTH / 8;

  // -------------------------------------------------------------------------
  // Unpack per-requester payload slices
  // -------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
  logic [BE_W-1:0]       be_arr    [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi] = wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
    assign be_arr[gi]    = be_i[gi*BE_W +: BE_W];
  end

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] req_elig;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;

  // A not-ready RAM simply hides every request from the picker, so no grant
  // is issued and the pointer holds.
  assign req_elig = req_i & {NUM_REQ{mem_ready_i}};

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .req_i   (req_elig),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt_oh),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  assign gnt_o = gnt_oh;

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (gnt_valid) begin
      mem_req_o   = 1'b1;
      mem_we_o    = we_i[gnt_idx];
      mem_addr_o  = addr_arr[gnt_idx];
      mem_wdata_o = wdata_arr[gnt_idx];
      mem_be_o    = be_arr[gnt_idx];
    end
  end

  // The winner drops to lowest priority for the next cycle.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid) begin
      ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : IDX_W'(gnt_idx + 1'b1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Response routing pipeline: stage 0 captures this cycle's grant, the last
  // stage lines up with mem_rdata_i. It never stalls.
  // -------------------------------------------------------------------------
  inflight_t pipe_q [RAM_LATENCY];
  inflight_t pipe_d [RAM_LATENCY];
  inflight_t head;

  always_comb begin
    pipe_d[0].valid = gnt_valid;
    pipe_d[0].idx   = IDX_MAX_W'(gnt_idx);
    for (int s = 1; s < RAM_LATENCY; s++) begin
      pipe_d[s] = pipe_q[s-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < RAM_LATENCY; s++) begin
        pipe_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < RAM_LATENCY; s++) begin
        pipe_q[s] <= pipe_d[s];
      end
    end
  end

  assign head = pipe_q[RAM_LATENCY-1];

  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    if (head.valid) begin
      rvalid_o = NUM_REQ'(1) << head.idx;
      rdata_o  = mem_rdata_i;
    end
  end

  // -------------------------------------------------------------------------
  // Optional statistics
  // -------------------------------------------------------------------------
`ifdef MEM_ARB_STATS_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt_cnt
    logic [STAT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (gnt_oh[gi] && (cnt_q != '1)) begin
        cnt_d = cnt_q + STAT_W'(1);
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign stat_gnt_cnt_o[gi*STAT_W +: STAT_W] = cnt_q;
  end

  logic              multi_req;
  logic [STAT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  // Clearing the lowest set bit leaves something only if two or more are set.
  assign multi_req = mem_ready_i && ((req_i & (req_i - NUM_REQ'(1))) != '0);

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (multi_req && (conflict_cnt_q != '1)) begin
      conflict_cnt_d = conflict_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_cnt_q <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign stat_conflict_cnt_o = conflict_cnt_q;
`endif

endmodule
